// File: rtl/uart_rx_if.sv
// Handshake bundle between the 8N1 serial receiver and its consumer.
// The master side drives the serial line and the acknowledge, the slave
// side (the receiver) drives the received byte and its status flags.
interface uart_rx_if;
    logic       RX;
    logic       clr_rdy;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frm_err;

    modport master (
        output RX,
        output clr_rdy,
        input  rx_data,
        input  rdy,
        input  frm_err
    );

    modport slave (
        input  RX,
        input  clr_rdy,
        output rx_data,
        output rdy,
        output frm_err
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 serial receiver. The line is synchronised through two flops, a low
// level seen in IDLE starts a frame, and each of the ten bits (start, eight
// data bits LSB first, stop) is sampled in the middle of its bit period.
// The assembled byte is presented with a sticky rdy flag and a framing-error
// flag that reflects the stop bit of that same byte.
module uart_rx #(
    parameter int BAUD_DIV = 2604
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave bus
);

    localparam int CW   = $clog2(BAUD_DIV);
    localparam int HALF = BAUD_DIV / 2;

    typedef enum logic {
        IDLE,
        RECEIVE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [1:0]      sync_q;
    logic            rx_s;
    logic [CW-1:0]   baud_cnt;
    logic [3:0]      bit_cnt;
    logic [8:0]      shift_q;
    logic            deliver_q;
    logic            init;
    logic            sample_tick;
    logic            finish;

    assign rx_s = sync_q[1];

    // State register; a reset abandons any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-cycle strobes: frame start, bit sample, frame end.
    always_comb begin
        state_next  = state;
        init        = 1'b0;
        sample_tick = 1'b0;
        finish      = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    init       = 1'b1;
                    state_next = RECEIVE;
                end
            end
            RECEIVE: begin
                if (baud_cnt == '0) begin
                    sample_tick = 1'b1;
                    if (bit_cnt == 4'd0 && rx_s) begin
                        state_next = IDLE;
                    end else if (bit_cnt == 4'd9) begin
                        finish     = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Two-flop synchroniser for the asynchronous line; resets to idle-high.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], bus.RX};
        end
    end

    // Baud and bit counters; the half-period preload puts samples mid-bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_cnt  <= 4'd0;
        end else begin
            if (init) begin
                baud_cnt <= CW'(HALF - 1);
                bit_cnt  <= 4'd0;
            end else if (state == RECEIVE) begin
                if (baud_cnt == '0) begin
                    baud_cnt <= CW'(BAUD_DIV - 1);
                end else begin
                    baud_cnt <= baud_cnt - CW'(1);
                end
                if (sample_tick) begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end
        end
    end

    // Shift samples in from the top; after the stop sample the low eight
    // bits hold the data byte and bit 8 holds the stop bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= 9'd0;
        end else if (sample_tick) begin
            shift_q <= {rx_s, shift_q[8:1]};
        end
    end

    // Delivery is delayed one cycle after the stop sample so the shift
    // register has settled; delivery beats both acknowledge and the clear
    // at the start of a following frame, so a break never loses a byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            deliver_q   <= 1'b0;
            bus.rx_data <= 8'h00;
            bus.rdy     <= 1'b0;
            bus.frm_err <= 1'b0;
        end else begin
            deliver_q <= finish;
            if (deliver_q) begin
                bus.rx_data <= shift_q[7:0];
                bus.rdy     <= 1'b1;
                bus.frm_err <= ~shift_q[8];
            end else if (init) begin
                bus.rdy     <= 1'b0;
                bus.frm_err <= 1'b0;
            end else if (bus.clr_rdy) begin
                bus.rdy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for the 8N1 receiver. A fast instance carries the functional and
// randomised traffic through a scoreboard; a default-rate instance covers
// the exact delivery latency at the production baud divider.
module tb_uart_rx;

    localparam int FAST = 32;
    localparam int FH   = FAST / 2;
    localparam int SLOW = 2604;
    localparam int SH   = SLOW / 2;

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         rdyCyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   testsRun = 0;
    int   testsFailed = 0;
    exp_t expQ[$];
    logic autoAck = 1'b0;
    int   forceClrEdge = -1;

    uart_rx_if ifFast ();
    uart_rx_if ifSlow ();

    uart_rx #(.BAUD_DIV(FAST)) dutFast (
        .clk (clk),
        .rst (rst),
        .bus (ifFast)
    );

    uart_rx dutSlow (
        .clk (clk),
        .rst (rst),
        .bus (ifSlow)
    );

    // Free-running clock and edge counter used to time-stamp events.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // One comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Drives one 8N1 frame on the fast instance and records what it should
    // produce: the byte, the inverted stop bit, and the edge at which rdy
    // must rise (two synchroniser edges, half a bit, nine bits, one more).
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input int gap,
                                 input int rstAtBit, input logic clrOnSet);
        logic [9:0] frame;
        int         startCyc;
        exp_t       e;
        frame    = {stopBit, data, 1'b0};
        startCyc = cyc;
        if (rstAtBit < 0) begin
            e.data   = data;
            e.err    = ~stopBit;
            e.rdyCyc = startCyc + 1 + 2 + FH + 9 * FAST + 1;
            expQ.push_back(e);
            if (clrOnSet) forceClrEdge = e.rdyCyc;
        end
        for (int k = 0; k < 10; k++) begin
            ifFast.RX = frame[k];
            if (rstAtBit >= 0 && k == rstAtBit + 1) begin
                repeat (FH) @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
                checkOutput("midFrameRstRdy", {31'd0, ifFast.rdy}, 32'd0);
                checkOutput("midFrameRstData", {24'd0, ifFast.rx_data}, 32'd0);
                checkOutput("midFrameRstErr", {31'd0, ifFast.frm_err}, 32'd0);
                repeat (FAST - FH - 1) @(posedge clk);
                #1;
            end else begin
                repeat (FAST) @(posedge clk);
                #1;
            end
        end
        ifFast.RX = 1'b1;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard monitor: every rising rdy must match the oldest expected byte.
    initial begin
        logic prevRdy;
        exp_t e;
        prevRdy = 1'b0;
        forever begin
            @(negedge clk);
            if (ifFast.rdy && !prevRdy) begin
                checkOutput("rdyExpected", {31'd0, expQ.size() > 0}, 32'd1);
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    checkOutput("rxData", {24'd0, ifFast.rx_data}, {24'd0, e.data});
                    checkOutput("frmErr", {31'd0, ifFast.frm_err}, {31'd0, e.err});
                    checkOutput("rdyCycle", cyc, e.rdyCyc);
                end
            end
            prevRdy = ifFast.rdy;
        end
    end

    // Consumer: owns clr_rdy; acknowledges each byte when enabled, or pulses
    // it exactly on a requested edge, and checks that an ack clears rdy only.
    initial begin
        logic       ackPending;
        logic [7:0] lastData;
        ackPending     = 1'b0;
        lastData       = 8'h00;
        ifFast.clr_rdy = 1'b0;
        forever begin
            @(negedge clk);
            if (ackPending) begin
                checkOutput("ackClearsRdy", {31'd0, ifFast.rdy}, 32'd0);
                checkOutput("ackKeepsData", {24'd0, ifFast.rx_data}, {24'd0, lastData});
                ackPending = 1'b0;
            end
            if (autoAck && ifFast.rdy) begin
                ifFast.clr_rdy = 1'b1;
                ackPending     = 1'b1;
                lastData       = ifFast.rx_data;
            end else begin
                ifFast.clr_rdy = (cyc + 1 == forceClrEdge);
            end
        end
    end

    // Watchdog so a stuck run still ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence.
    initial begin
        logic [9:0] slowFrame;
        int         slowStart;
        int         seen;
        logic [7:0] rndData;
        logic       rndStop;
        int         rndGap;

        rst            = 1'b1;
        ifFast.RX      = 1'b1;
        ifSlow.RX      = 1'b1;
        ifSlow.clr_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        checkOutput("resetRdy", {31'd0, ifFast.rdy}, 32'd0);
        checkOutput("resetData", {24'd0, ifFast.rx_data}, 32'd0);
        checkOutput("resetErr", {31'd0, ifFast.frm_err}, 32'd0);
        checkOutput("resetSlowRdy", {31'd0, ifSlow.rdy}, 32'd0);

        repeat (10000) @(posedge clk);
        #1;
        checkOutput("idleRdy", {31'd0, ifFast.rdy}, 32'd0);
        checkOutput("idleErr", {31'd0, ifFast.frm_err}, 32'd0);
        checkOutput("idleData", {24'd0, ifFast.rx_data}, 32'd0);
        checkOutput("idleSlowRdy", {31'd0, ifSlow.rdy}, 32'd0);
        checkOutput("idleSlowData", {24'd0, ifSlow.rx_data}, 32'd0);

        // Production-rate frame: exact rdy latency, data, acknowledge.
        $display("[TB] default-rate frame 8'hA5");
        slowFrame = {1'b1, 8'hA5, 1'b0};
        slowStart = cyc;
        seen      = -1;
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    ifSlow.RX = slowFrame[k];
                    repeat (SLOW) @(posedge clk);
                    #1;
                end
                ifSlow.RX = 1'b1;
            end
            begin
                for (int i = 0; i < 11 * SLOW && seen < 0; i++) begin
                    @(negedge clk);
                    if (ifSlow.rdy) seen = cyc;
                end
            end
        join
        checkOutput("slowRdyCycle", seen, slowStart + 1 + 2 + 24739);
        checkOutput("slowData", {24'd0, ifSlow.rx_data}, 32'hA5);
        checkOutput("slowErr", {31'd0, ifSlow.frm_err}, 32'd0);
        ifSlow.clr_rdy = 1'b1;
        @(posedge clk);
        #1 ifSlow.clr_rdy = 1'b0;
        checkOutput("slowClrRdy", {31'd0, ifSlow.rdy}, 32'd0);
        checkOutput("slowClrKeepsData", {24'd0, ifSlow.rx_data}, 32'hA5);

        // Back-to-back frames, each acknowledged.
        $display("[TB] back-to-back frames");
        autoAck = 1'b1;
        applyStimulus(8'h00, 1'b1, 0, -1, 1'b0);
        applyStimulus(8'hFF, 1'b1, 0, -1, 1'b0);
        applyStimulus(8'h55, 1'b1, 0, -1, 1'b0);
        applyStimulus(8'h3C, 1'b1, 2 * FAST, -1, 1'b0);
        checkOutput("backToBackDrained", expQ.size(), 32'd0);

        // Short low pulse is a false start; the next frame still decodes.
        $display("[TB] false start");
        ifFast.RX = 1'b0;
        repeat (10) @(posedge clk);
        #1 ifFast.RX = 1'b1;
        repeat (2 * FAST) @(posedge clk);
        #1;
        checkOutput("falseStartNoRdy", {31'd0, ifFast.rdy}, 32'd0);
        applyStimulus(8'h81, 1'b1, 2 * FAST, -1, 1'b0);

        // Framing error, overwrite without ack, ack on the set edge.
        $display("[TB] framing error and overwrite");
        autoAck = 1'b0;
        applyStimulus(8'h7E, 1'b0, 2 * FAST, -1, 1'b0);
        checkOutput("frmErrRdy", {31'd0, ifFast.rdy}, 32'd1);
        checkOutput("frmErrData", {24'd0, ifFast.rx_data}, 32'h7E);
        checkOutput("frmErrFlag", {31'd0, ifFast.frm_err}, 32'd1);
        applyStimulus(8'h12, 1'b1, 2 * FAST, -1, 1'b1);
        checkOutput("setBeatsClrRdy", {31'd0, ifFast.rdy}, 32'd1);
        checkOutput("overwriteData", {24'd0, ifFast.rx_data}, 32'h12);
        checkOutput("overwriteErr", {31'd0, ifFast.frm_err}, 32'd0);

        // Reset in the middle of data bit 4 abandons the frame.
        $display("[TB] reset mid-frame");
        applyStimulus(8'hF5, 1'b1, 2 * FAST, 4, 1'b0);
        checkOutput("abandonedNoRdy", {31'd0, ifFast.rdy}, 32'd0);
        applyStimulus(8'hC3, 1'b1, 2 * FAST, -1, 1'b0);
        checkOutput("afterRstData", {24'd0, ifFast.rx_data}, 32'hC3);

        // Random traffic with occasional framing errors and random gaps.
        $display("[TB] random frames");
        autoAck = 1'b1;
        for (int n = 0; n < 16; n++) begin
            rndData = 8'($urandom);
            rndStop = ($urandom_range(0, 4) != 0);
            rndGap  = rndStop ? int'($urandom_range(0, 2 * FAST)) : FAST + int'($urandom_range(0, FAST));
            applyStimulus(rndData, rndStop, rndGap, -1, 1'b0);
        end
        repeat (2 * FAST) @(posedge clk);
        #1;
        checkOutput("scoreboardEmpty", expQ.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver; the downstream neighbour of the UART transmitter.
- Consumes the 8N1 serial line the transmitter drives: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), line idles high.
- Samples each bit at mid-bit, assembles the byte and presents it with a ready flag that persists until consumed.
- Same baud timing as the transmitter: 2604 clk per bit (50 MHz, 19200 baud).

Parameters:
BAUD_DIV, 2604, clk cycles per bit; must be even and >= 8; the counter is 12 bits wide at the default value.

Ports:
clk  input  1  system clock; one clock domain; all logic on posedge clk.
rst  input  1  reset; synchronous, active-high.
RX  input  1  asynchronous serial input; idle high.
clr_rdy  input  1  consumer acknowledge; clears rdy.
rx_data  output  8  received byte; valid while rdy=1.
rdy  output  1  byte available; level, sticky until cleared.
frm_err  output  1  stop bit sampled 0 for the byte currently in rx_data; valid with rdy.

Behaviour:
- Reset (rst=1 at a clock edge):
  - rx_data=8'h00, rdy=0, frm_err=0.
  - State=IDLE; both synchronizer flops=1.
  - Reset mid-frame abandons the frame; no rdy results from it.
- Synchronizer:
  - RX passes through 2 flops to give rx_s; all decisions use rx_s only.
- State IDLE:
  - When rx_s==0 (this is the "init" cycle, t=0): go to RECEIVE, bit_cnt=0, baud counter loaded so that the first sample falls at t=BAUD_DIV/2.
  - Init also clears rdy and frm_err.
- State RECEIVE:
  - The baud counter runs every cycle.
  - Sample k (k=0..9) is taken at t = BAUD_DIV/2 + k*BAUD_DIV.
  - At each sample: shift rx_s into a 9-bit shift register from the MSB end, then bit_cnt++.
  - Sample 0 = start bit. If rx_s==1 at sample 0 (glitch/false start): return to IDLE immediately, no rdy, rx_data unchanged.
  - Samples 1..8 = data bits 0..7.
  - Sample 9 = stop bit. Return to IDLE. In the next cycle: rdy=1, rx_data=data bits, frm_err = ~stop_sample.
  - The byte is delivered even on a framing error.
  - Timing at default: rdy rises at t=24739 (1302+9*2604+1).
- Return to IDLE after the stop sample:
  - Occurs at mid-stop-bit.
  - A new start bit is accepted as soon as rx_s==0 is seen in IDLE.
  - If the line is still low (break / framing error), a new frame starts immediately.
- rdy and clr_rdy:
  - clr_rdy=1 clears rdy on the next edge; rx_data holds its value.
  - Set and clr_rdy in the same cycle: set wins (rdy=1).
  - clr_rdy while rdy=0: no effect.
  - Overrun: a new byte completing while rdy=1 overwrites rx_data; rdy stays 1. No overrun flag.
  - rdy is also cleared at init of the next frame.
- Widths:
  - baud counter: ceil(log2(BAUD_DIV)) bits.
  - bit_cnt: 4 bits; values 0..10 only.
- Throughout RECEIVE, transitions on rx_s between samples are ignored.

Test Plan:
- Reset, then RX idle high for 10000 cycles -> rdy=0, frm_err=0, rx_data=8'h00; state stays IDLE.
- Drive 8'hA5 as 8N1 at 2604 clk/bit, start edge at cycle T -> rdy rises exactly T+2+24739 (2 synchronizer cycles), rx_data=8'hA5, frm_err=0; assert clr_rdy 1 cycle -> rdy=0, rx_data still 8'hA5.
- Loopback with the transmitter: send 8'h00, 8'hFF, 8'h55, 8'h3C back to back, clr_rdy pulsed on each rdy -> 4 rdy pulses, bytes received in order, frm_err=0 each.
- RX low pulse of 500 cycles then high -> start sample reads 1; no rdy; back in IDLE; a following 8'h81 frame is received correctly.
- Frame 8'h7E with stop bit forced 0 -> rdy=1, rx_data=8'h7E, frm_err=1. Second frame 8'h12 sent without clr_rdy -> rx_data=8'h12, rdy=1, frm_err=0. clr_rdy asserted on the cycle rdy is set -> rdy remains 1.
- rst=1 for 1 cycle midway through data bit 4 of a frame -> all outputs return to reset values; remainder of the frame produces no rdy; next full frame 8'hC3 is received correctly.
